// File: rtl/mux_logic_gates_if.sv
// Operand/result bundle for mux_logic_gates.
// MUX_GATES_STATUS_EN adds the all_and/any_nor status outputs.
interface mux_logic_gates_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_nor;
`ifdef MUX_GATES_STATUS_EN
  logic             all_and;
  logic             any_nor;

  modport master (
    output in_valid, a, b,
    input  out_valid, y_and, y_nand, y_nor, all_and, any_nor
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, y_and, y_nand, y_nor, all_and, any_nor
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, y_and, y_nand, y_nor
  );
  modport slave (
    input  in_valid, a, b,
    output out_valid, y_and, y_nand, y_nor
  );
`endif
endinterface

// File: rtl/mux_logic_gates.sv
// Registered bitwise AND/NAND/NOR built only from 2:1 mux cells, one-cycle latency.
// Optional MUX_GATES_STATUS_EN adds registered all_and/any_nor status bits.
module mux2 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic s_i,
  output logic y_o
);
  assign y_o = s_i ? d1_i : d0_i;
endmodule

module mux_logic_gates #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_logic_gates_if.slave    bus
);
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] and_w, nand_w, nor_w;
  logic [WIDTH-1:0] y_and_d, y_and_q, y_nand_d, y_nand_q, y_nor_d, y_nor_q;
  logic             out_valid_d, out_valid_q;

  assign a_n = ~bus.a;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_and  (.d0_i(1'b0),   .d1_i(bus.a[i]), .s_i(bus.b[i]), .y_o(and_w[i]));
    mux2 u_nand (.d0_i(1'b1),   .d1_i(a_n[i]),   .s_i(bus.b[i]), .y_o(nand_w[i]));
    mux2 u_nor  (.d0_i(a_n[i]), .d1_i(1'b0),     .s_i(bus.b[i]), .y_o(nor_w[i]));
  end

  // Results only load on in_valid, so a/b are never sampled otherwise.
  always_comb begin
    y_and_d     = y_and_q;
    y_nand_d    = y_nand_q;
    y_nor_d     = y_nor_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_and_d  = and_w;
      y_nand_d = nand_w;
      y_nor_d  = nor_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_and_q     <= '0;
      y_nand_q    <= '0;
      y_nor_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_and_q     <= y_and_d;
      y_nand_q    <= y_nand_d;
      y_nor_q     <= y_nor_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y_and     = y_and_q;
  assign bus.y_nand    = y_nand_q;
  assign bus.y_nor     = y_nor_q;

`ifdef MUX_GATES_STATUS_EN
  // Reductions are mux chains: all_and passes 1 only while every and bit selects it,
  // any_nor latches to 1 once any nor bit selects the constant.
  logic [WIDTH:0] all_chain, any_chain;
  logic           all_and_d, all_and_q, any_nor_d, any_nor_q;

  assign all_chain[0] = 1'b1;
  assign any_chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stat
    mux2 u_all (.d0_i(1'b0), .d1_i(all_chain[i]), .s_i(and_w[i]), .y_o(all_chain[i+1]));
    mux2 u_any (.d0_i(any_chain[i]), .d1_i(1'b1), .s_i(nor_w[i]), .y_o(any_chain[i+1]));
  end

  always_comb begin
    all_and_d = all_and_q;
    any_nor_d = any_nor_q;
    if (bus.in_valid) begin
      all_and_d = all_chain[WIDTH];
      any_nor_d = any_chain[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_and_q <= 1'b0;
      any_nor_q <= 1'b0;
    end else begin
      all_and_q <= all_and_d;
      any_nor_q <= any_nor_d;
    end
  end

  assign bus.all_and = all_and_q;
  assign bus.any_nor = any_nor_q;
`endif
endmodule

// File: tb/tb_mux_logic_gates.sv
// Bench for mux_logic_gates: a 1-bit and a 4-bit instance share one stimulus stream
// (the 1-bit one sees bit 0) and are compared with a behavioural &/| model.
module tb_mux_logic_gates;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_logic_gates_if #(.WIDTH(1)) bus1 ();
  mux_logic_gates_if #(.WIDTH(4)) bus4 ();

  mux_logic_gates #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_logic_gates #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int errors = 0;
  int checks = 0;

  // Model state: registered view of the 4-bit instance; bit 0 serves the 1-bit one.
  logic [3:0] m_and, m_nand, m_nor;
  logic       m_v, m_all, m_any;

  typedef struct {
    logic [3:0] a, b, e_and, e_nand, e_nor;
    logic       wide;
  } vec_t;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_and = '0; m_nand = '0; m_nor = '0; m_v = 1'b0; m_all = 1'b0; m_any = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    bus4.in_valid = v; bus4.a = a; bus4.b = b;
    bus1.in_valid = v; bus1.a = a[0]; bus1.b = b[0];
  endtask

  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b);
    drive(v, a, b);
    @(posedge clk);
    #1;
    if (v) begin
      m_and  = a & b;
      m_nand = ~(a & b);
      m_nor  = ~(a | b);
      m_all  = ((a & b) == 4'hF);
      m_any  = (~(a | b) != 4'h0);
    end
    m_v = v;
  endtask

  task automatic check_model(input string t);
    chk({t, " w4 out_valid"}, {3'b0, bus4.out_valid}, {3'b0, m_v});
    chk({t, " w4 y_and"},  bus4.y_and,  m_and);
    chk({t, " w4 y_nand"}, bus4.y_nand, m_nand);
    chk({t, " w4 y_nor"},  bus4.y_nor,  m_nor);
    chk({t, " w1 out_valid"}, {3'b0, bus1.out_valid}, {3'b0, m_v});
    chk({t, " w1 y_and"},  {3'b0, bus1.y_and},  {3'b0, m_and[0]});
    chk({t, " w1 y_nand"}, {3'b0, bus1.y_nand}, {3'b0, m_nand[0]});
    chk({t, " w1 y_nor"},  {3'b0, bus1.y_nor},  {3'b0, m_nor[0]});
`ifdef MUX_GATES_STATUS_EN
    chk({t, " w4 all_and"}, {3'b0, bus4.all_and}, {3'b0, m_all});
    chk({t, " w4 any_nor"}, {3'b0, bus4.any_nor}, {3'b0, m_any});
    chk({t, " w1 all_and"}, {3'b0, bus1.all_and}, {3'b0, m_and[0]});
    chk({t, " w1 any_nor"}, {3'b0, bus1.any_nor}, {3'b0, m_nor[0]});
`endif
  endtask

  task automatic check_zero(input string t);
    chk({t, " w4 out_valid"}, {3'b0, bus4.out_valid}, 4'h0);
    chk({t, " w4 y_and"},  bus4.y_and,  4'h0);
    chk({t, " w4 y_nand"}, bus4.y_nand, 4'h0);
    chk({t, " w4 y_nor"},  bus4.y_nor,  4'h0);
    chk({t, " w1 y_nand"}, {3'b0, bus1.y_nand}, 4'h0);
`ifdef MUX_GATES_STATUS_EN
    chk({t, " w4 all_and"}, {3'b0, bus4.all_and}, 4'h0);
    chk({t, " w4 any_nor"}, {3'b0, bus4.any_nor}, 4'h0);
`endif
  endtask

  initial begin
    vec_t tab[7];
    // T1 on the 1-bit instance ({a,b} = 00,01,10,11), then T4 patterns on the 4-bit one.
    tab[0] = '{a: 4'h0, b: 4'h0, e_and: 4'h0, e_nand: 4'h1, e_nor: 4'h1, wide: 1'b0};
    tab[1] = '{a: 4'h0, b: 4'h1, e_and: 4'h0, e_nand: 4'h1, e_nor: 4'h0, wide: 1'b0};
    tab[2] = '{a: 4'h1, b: 4'h0, e_and: 4'h0, e_nand: 4'h1, e_nor: 4'h0, wide: 1'b0};
    tab[3] = '{a: 4'h1, b: 4'h1, e_and: 4'h1, e_nand: 4'h0, e_nor: 4'h0, wide: 1'b0};
    tab[4] = '{a: 4'b1100, b: 4'b1010, e_and: 4'b1000, e_nand: 4'b0111, e_nor: 4'b0001,
               wide: 1'b1};
    tab[5] = '{a: 4'hF, b: 4'hF, e_and: 4'hF, e_nand: 4'h0, e_nor: 4'h0, wide: 1'b1};
    tab[6] = '{a: 4'h0, b: 4'h0, e_and: 4'h0, e_nand: 4'hF, e_nor: 4'hF, wide: 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // T1/T4 table, back-to-back in_valid.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, tab[i].a, tab[i].b);
      if (tab[i].wide) begin
        chk($sformatf("tab%0d y_and", i),  bus4.y_and,  tab[i].e_and);
        chk($sformatf("tab%0d y_nand", i), bus4.y_nand, tab[i].e_nand);
        chk($sformatf("tab%0d y_nor", i),  bus4.y_nor,  tab[i].e_nor);
        chk($sformatf("tab%0d out_valid", i), {3'b0, bus4.out_valid}, 4'h1);
      end else begin
        chk($sformatf("tab%0d y_and", i),  {3'b0, bus1.y_and},  tab[i].e_and);
        chk($sformatf("tab%0d y_nand", i), {3'b0, bus1.y_nand}, tab[i].e_nand);
        chk($sformatf("tab%0d y_nor", i),  {3'b0, bus1.y_nor},  tab[i].e_nor);
        chk($sformatf("tab%0d out_valid", i), {3'b0, bus1.out_valid}, 4'h1);
      end
`ifdef MUX_GATES_STATUS_EN
      if (i == 5) begin
        chk("T5 all_and hi", {3'b0, bus4.all_and}, 4'h1);
        chk("T5 any_nor hi", {3'b0, bus4.any_nor}, 4'h0);
      end
      if (i == 6) begin
        chk("T5 all_and lo", {3'b0, bus4.all_and}, 4'h0);
        chk("T5 any_nor lo", {3'b0, bus4.any_nor}, 4'h1);
      end
`endif
      check_model($sformatf("tab%0d", i));
    end

    // T3: capture all-ones, then hold through 3 idle cycles with operands changed.
    cycle(1'b1, 4'hF, 4'hF);
    check_model("T3 cap");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'h0, 4'h0);
      chk($sformatf("T3 hold%0d y_and", i),  bus4.y_and,  4'hF);
      chk($sformatf("T3 hold%0d y_nand", i), bus4.y_nand, 4'h0);
      chk($sformatf("T3 hold%0d y_nor", i),  bus4.y_nor,  4'h0);
      chk($sformatf("T3 hold%0d out_valid", i), {3'b0, bus4.out_valid}, 4'h0);
      check_model($sformatf("T3 hold%0d", i));
    end

    // T2: reset mid-stream clears outputs before any clock edge.
    cycle(1'b1, 4'hF, 4'hF);
    drive(1'b1, 4'hF, 4'hF);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("T2 async");
    @(posedge clk);
    #1;
    check_zero("T2 held");
    drive(1'b0, 4'hF, 4'hF);
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 4'hF, 4'hF);
    check_zero("T2 release");
    check_model("T2 release");

    // T6: random operands with toggling in_valid.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'($urandom_range(1, 0)), 4'($urandom), 4'($urandom));
      check_model($sformatf("T6 c%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
